// File: rtl/shared_bus_arbiter.sv
// Round-robin arbiter for a shared bidirectional pad bus. Grants one requester
// at a time, bounds each tenure, and inserts a one-cycle turnaround between tenures.
module shared_bus_arbiter #(
   parameter int N_REQ    = 3,
   parameter int DW       = 5,
   parameter int HOLD_MAX = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req,
   input  logic [N_REQ-1:0]   wr,
   input  logic [N_REQ-1:0]   done,
   input  logic [N_REQ*DW-1:0] wdata,
   input  logic [DW-1:0]      bus_din,
   output logic [DW-1:0]      bus_dout,
   output logic               bus_oe,
   output logic [N_REQ-1:0]   gnt,
   output logic [DW-1:0]      rdata,
   output logic [N_REQ-1:0]   rvalid,
   output logic               timeout
);

   localparam int              PW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [7:0]      HOLD_LAST = 8'(HOLD_MAX - 1);
   localparam logic [PW-1:0]   PTR_RST   = PW'(N_REQ - 1);

   typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

   state_t           state, state_nx;
   logic [PW-1:0]    ptr, ptr_nx, pick;
   logic [N_REQ-1:0] gnt_nx;
   logic [7:0]       hold_cnt, hold_nx;
   logic             timeout_nx;
   logic             found;

   // ptr doubles as the owner index while in GRANT; search starts just past it
   always_comb begin : rr_search
      int            cand;
      logic [PW-1:0] cidx;
      cand  = 0;
      cidx  = '0;
      pick  = ptr;
      found = 1'b0;
      for (int off = 1; off <= N_REQ; off++) begin
         cand = (int'(ptr) + off) % N_REQ;
         cidx = PW'(cand);
         if (!found && req[cidx]) begin
            found = 1'b1;
            pick  = cidx;
         end
      end
   end

   always_comb begin
      state_nx   = state;
      gnt_nx     = '0;
      ptr_nx     = ptr;
      hold_nx    = hold_cnt;
      timeout_nx = 1'b0;
      case (state)
         IDLE, TURN: begin
            if (found) begin
               state_nx     = GRANT;
               gnt_nx[pick] = 1'b1;
               ptr_nx       = pick;
               hold_nx      = '0;
            end else begin
               state_nx = IDLE;
            end
         end
         GRANT: begin
            // a normal release wins over a coincident hold expiry
            if (!req[ptr] || done[ptr]) begin
               state_nx = TURN;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nx   = TURN;
               timeout_nx = 1'b1;
            end else begin
               gnt_nx  = gnt;
               hold_nx = hold_cnt + 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         ptr      <= PTR_RST;
         hold_cnt <= '0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         ptr      <= ptr_nx;
         hold_cnt <= hold_nx;
         timeout  <= timeout_nx;
      end
   end

   // pad drive decodes from registered state so reset drops it immediately
   assign bus_oe   = (state == GRANT) && wr[ptr];
   assign bus_dout = bus_oe ? wdata[int'(ptr)*DW +: DW] : '0;
   assign rdata    = bus_din;
   assign rvalid   = gnt & ~wr;

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: tenure-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_shared_bus_arbiter;

   localparam int N    = 3;
   localparam int DW   = 5;
   localparam int HOLD = 8;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [N-1:0]    req = '0, wr = '0, done = '0;
   logic [N*DW-1:0] wdata = '0;
   logic [DW-1:0]   bus_din = '0;
   logic [DW-1:0]   bus_dout, rdata;
   logic            bus_oe, timeout;
   logic [N-1:0]    gnt, rvalid;

   int total = 0;
   int passed = 0;

   shared_bus_arbiter #(.N_REQ(N), .DW(DW), .HOLD_MAX(HOLD)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .done(done),
      .wdata(wdata), .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe),
      .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .timeout(timeout)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference model: owner (-1 = nobody), tenure length, last granted index.
   int m_owner = -1;
   int m_last  = N - 1;
   int m_len   = 0;
   bit m_to    = 1'b0;

   initial begin : model
      int c;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_owner = -1; m_last = N - 1; m_len = 0; m_to = 1'b0;
         end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
               for (int k = 1; k <= N; k++) begin
                  c = (m_last + k) % N;
                  if (m_owner < 0 && req[c]) begin
                     m_owner = c; m_last = c; m_len = 1;
                  end
               end
            end else if (!req[m_owner] || done[m_owner]) begin
               m_owner = -1;
            end else if (m_len == HOLD) begin
               m_owner = -1; m_to = 1'b1;
            end else begin
               m_len++;
            end
         end
      end
   end

   always @(negedge clk) begin : compare
      logic [N-1:0]  eg;
      logic          eoe;
      logic [DW-1:0] edo;
      eg  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      eoe = (m_owner >= 0) && wr[m_owner];
      edo = eoe ? wdata[m_owner*DW +: DW] : '0;
      chk("m_gnt", 32'(gnt), 32'(eg));
      chk("m_bus_oe", 32'(bus_oe), 32'(eoe));
      chk("m_bus_dout", 32'(bus_dout), 32'(edo));
      chk("m_rvalid", 32'(rvalid), 32'(eg & ~wr));
      chk("m_rdata", 32'(rdata), 32'(bus_din));
      chk("m_timeout", 32'(timeout), 32'(m_to));
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic sample();
      #4;
   endtask

   logic [N-1:0] seq_gnt [10] = '{3'b001, 3'b001, 3'b000, 3'b010, 3'b010,
                                  3'b000, 3'b100, 3'b100, 3'b000, 3'b001};
   logic [N-1:0] seq_done[10] = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b010,
                                  3'b000, 3'b000, 3'b100, 3'b000, 3'b000};

   initial begin
      // reset state
      #3;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_oe", 32'(bus_oe), 32'h0);
      chk("rst_dout", 32'(bus_dout), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // round robin with done on each tenure's second cycle
      req = 3'b111;
      for (int i = 0; i < 10; i++) begin
         tick();
         done = seq_done[i];
         sample();
         chk($sformatf("rr_gnt%0d", i), 32'(gnt), 32'(seq_gnt[i]));
      end
      done = '0; req = '0;
      tick(); tick(); tick();

      // forced release of a writer after HOLD cycles, then regrant
      wr = 3'b010;
      wdata = '0;
      wdata[9:5] = 5'b10110;
      req = 3'b010;
      for (int i = 0; i < HOLD; i++) begin
         tick(); sample();
         chk($sformatf("wr_oe%0d", i), 32'(bus_oe), 32'h1);
         chk($sformatf("wr_dout%0d", i), 32'(bus_dout), 32'h16);
      end
      tick(); sample();
      chk("to_gnt", 32'(gnt), 32'h0);
      chk("to_pulse", 32'(timeout), 32'h1);
      chk("to_oe", 32'(bus_oe), 32'h0);
      tick(); sample();
      chk("regrant_gnt", 32'(gnt), 32'h2);
      chk("regrant_to", 32'(timeout), 32'h0);

      // async reset mid-grant
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_oe", 32'(bus_oe), 32'h0);
      chk("arst_gnt", 32'(gnt), 32'h0);
      req = 3'b100; wr = '0;
      #1 rst_n = 1'b1;
      tick(); sample();
      chk("post_rst_gnt", 32'(gnt), 32'h4);
      req = '0;
      tick(); tick(); tick();

      // reader broadcast
      bus_din = 5'b01011;
      req = 3'b001;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick(); sample();
         chk($sformatf("rd_rvalid%0d", i), 32'(rvalid), 32'h1);
         chk($sformatf("rd_rdata%0d", i), 32'(rdata), 32'h0b);
         chk($sformatf("rd_oe%0d", i), 32'(bus_oe), 32'h0);
      end
      req = '0;
      tick(); tick(); tick();

      // done coinciding with the last hold cycle is a normal release
      wr = 3'b001;
      wdata[4:0] = 5'h1f;
      req = 3'b001;
      for (int i = 1; i <= HOLD; i++) begin
         tick();
         if (i == HOLD) done = 3'b001;
      end
      tick();
      done = '0;
      sample();
      chk("coinc_gnt", 32'(gnt), 32'h0);
      chk("coinc_timeout", 32'(timeout), 32'h0);
      req = '0;
      tick(); tick();

      // pseudo-random traffic checked by the model
      for (int i = 0; i < 400; i++) begin
         tick();
         if ($urandom_range(0, 3) == 0) begin
            req = N'($urandom_range(0, 7));
            wr  = N'($urandom_range(0, 7));
         end
         done    = ($urandom_range(0, 5) == 0) ? N'($urandom_range(1, 7)) : '0;
         wdata   = (N*DW)'($urandom);
         bus_din = DW'($urandom);
      end
      req = '0; done = '0;
      tick(); tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/shared_bus_arbiter.md
SHARED_BUS_ARBITER -- requirements
Module: shared_bus_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 5, shared bidirectional bus width.
REQ-003 SHALL have parameter HOLD_MAX, default 8, maximum consecutive grant cycles per tenure (2..255).
REQ-004 SHALL have clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have req  input  N_REQ  per-requester bus request, level-held.
REQ-007 SHALL have wr  input  N_REQ  per-requester direction, 1=drive bus, 0=read bus.
REQ-008 SHALL have done  input  N_REQ  per-requester early release, single-cycle.
REQ-009 SHALL have wdata  input  N_REQ*DW  packed write data, requester i at [i*DW +: DW].
REQ-010 SHALL have bus_din  input  DW  value sampled from the inout pad.
REQ-011 SHALL have bus_dout  output  DW  value driven onto the inout pad.
REQ-012 SHALL have bus_oe  output  1  pad output enable, 1=drive.
REQ-013 SHALL have gnt  output  N_REQ  one-hot grant, registered.
REQ-014 SHALL have rdata  output  DW  bus_din broadcast to readers.
REQ-015 SHALL have rvalid  output  N_REQ  gnt & ~wr, combinational.
REQ-016 SHALL have timeout  output  1  single-cycle pulse on forced release.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT, TURN.
REQ-018 SHALL arbitrate in IDLE and TURN: if any req, next state GRANT, gnt set one-hot to first set req index searching from ptr+1 upward, wrapping modulo N_REQ; else next state IDLE.
REQ-019 SHALL update ptr to granted index on each grant; ptr resets to N_REQ-1 so index 0 has first priority.
REQ-020 SHALL give req-to-gnt latency of exactly one cycle from IDLE (req high at edge k -> gnt high after edge k+1 sampling... i.e. visible in cycle k+1).
REQ-021 SHALL hold GRANT while req[g]=1, done[g]=0 and hold_cnt < HOLD_MAX-1; hold_cnt clears on grant and increments each GRANT cycle.
REQ-022 SHALL leave GRANT to TURN when req[g]=0 or done[g]=1 (normal) or hold_cnt = HOLD_MAX-1 (forced, timeout=1 in the TURN cycle).
REQ-023 SHALL, when normal and forced release coincide, treat as normal: timeout=0.
REQ-024 SHALL spend exactly one cycle in TURN with gnt=0 and bus_oe=0 (bus turnaround, no contention).
REQ-025 SHALL drive bus_oe = 1 only in GRANT with wr[g]=1; bus_dout = wdata slice g when bus_oe=1, else 0.
REQ-026 SHALL ignore req/done/wr of non-granted requesters during GRANT.
REQ-027 SHALL never assert more than one gnt bit; gnt=0 in IDLE and TURN.
REQ-028 SHALL treat a requester that re-requests after release as lowest priority relative to waiting others (round-robin fairness, max wait (N_REQ-1)*(HOLD_MAX+1) cycles).

Reset
REQ-029 SHALL, on rst_n=0, immediately (asynchronously) force state=IDLE, gnt=0, bus_oe=0, bus_dout=0, timeout=0, hold_cnt=0, ptr=N_REQ-1.
REQ-030 SHALL, if reset asserts mid-GRANT, drop bus_oe in the same cycle without a TURN cycle; first grant after reset release follows REQ-018.

Verification
REQ-031 Reset release, req=3'b111 constant, done pulsed each tenure's 2nd cycle -> gnt sequence 001,TURN,010,TURN,100,TURN,001.
REQ-032 req=3'b010, wr=3'b010, wdata[9:5]=5'b10110, held > 8 cycles -> bus_oe=1, bus_dout=10110 for 8 cycles, then TURN with timeout=1, gnt=0, then regrant 010.
REQ-033 req[0]=1 wr[0]=0, bus_din=5'b01011 -> rvalid=001, rdata=01011, bus_oe=0 throughout.
REQ-034 done and hold_cnt=7 same cycle -> TURN entered, timeout=0.
REQ-035 rst_n low during GRANT with bus_oe=1 -> bus_oe, gnt 0 before next clk edge; after release req=3'b100 -> gnt=100 one cycle later.
